param_dpram: RTL and testbench

PARAM_DPRAM -- requirements
Module: param_dpram

---
 rtl/param_dpram_pkg.sv | 14 +
 rtl/dpram_port.sv | 69 ++++++
 rtl/param_dpram.sv | 133 +++++++++++++
 tb/tb_param_dpram.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_dpram_pkg.sv
// Shared definitions for the parameterised dual-port RAM: write-mode codes and
// the clear-sweep state type.
package param_dpram_pkg;

  localparam int unsigned WM_WRITE_FIRST = 0;
  localparam int unsigned WM_READ_FIRST  = 1;
  localparam int unsigned WM_NO_CHANGE   = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

endpackage

// File: rtl/dpram_port.sv
// One RAM port's output path: write-mode mux, SRVAL reset and the optional
// output pipeline stage.
module dpram_port
  import param_dpram_pkg::*;
#(
  parameter int unsigned       DATA_W     = 18,
  parameter int unsigned       WRITE_MODE = WM_WRITE_FIRST,
  parameter logic [DATA_W-1:0] SRVAL      = '0,
  parameter bit                OUT_REG    = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              access,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] lat_q, lat_d;

  always_comb begin
    // NOTE: default to the held value first so every path assigns lat_d and no latch is inferred.
    lat_d = lat_q;
    if (access) begin
      if (!we) begin
        lat_d = mem_rdata;
      end else begin
        case (WRITE_MODE)
          WM_WRITE_FIRST: lat_d = din;
          WM_READ_FIRST:  lat_d = mem_rdata;
          default:        lat_d = lat_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_q <= SRVAL;
    end else begin
      lat_q <= lat_d;
    end
  end

  // The output stage advances every cycle, so a held first stage also holds dout.
  generate
    if (OUT_REG) begin : g_out_reg
      logic [DATA_W-1:0] out_q, out_d;

      always_comb begin
        out_d = lat_q;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          out_q <= SRVAL;
        end else begin
          out_q <= out_d;
        end
      end

      assign dout = out_q;
    end else begin : g_no_out_reg
      assign dout = lat_q;
    end
  endgenerate

endmodule

// File: rtl/param_dpram.sv
// Single-clock true dual-port RAM with per-port write modes, collision flag
// and an optional post-reset clear sweep.
module param_dpram
  import param_dpram_pkg::*;
#(
  parameter int unsigned       DATA_W         = 18,
  parameter int unsigned       ADDR_W         = 10,
  parameter int unsigned       WRITE_MODE_A   = WM_WRITE_FIRST,
  parameter int unsigned       WRITE_MODE_B   = WM_WRITE_FIRST,
  parameter logic [DATA_W-1:0] SRVAL_A        = '0,
  parameter logic [DATA_W-1:0] SRVAL_B        = '0,
  parameter bit                OUT_REG        = 1'b0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clka,
  input  logic              reset,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  input  logic              enb,
  input  logic              web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dinb,
  output logic [DATA_W-1:0] doutb,
  output logic              busy,
  output logic              collision
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [DATA_W-1:0] mem [DEPTH];

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              collision_q, collision_d;

  logic acc_a, acc_b, wr_a, wr_b, same_addr, clr_we;
  logic [DATA_W-1:0] rdata_a, rdata_b;

  // Clear sweep: one word per cycle, stops on the last address instead of wrapping.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == CLEAR) begin
      if (sweep_q == LAST_ADDR) begin
        state_d = READY;
      end else begin
        sweep_d = sweep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : READY;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  assign busy = (state_q == CLEAR);

  always_comb begin
    clr_we      = busy && !reset;
    acc_a       = ena && !busy && !reset;
    acc_b       = enb && !busy && !reset;
    same_addr   = (addra == addrb);
    wr_a        = acc_a && wea;
    // Port A wins a same-address double write.
    wr_b        = acc_b && web && !(wr_a && same_addr);
    collision_d = acc_a && acc_b && same_addr && (wea || web);
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= collision_d;
    end
  end

  assign collision = collision_q;

  // NOTE: the array has no reset term; the clear sweep zeroes it, and a reset would block RAM inference.
  always_ff @(posedge clka) begin
    if (clr_we) begin
      mem[sweep_q] <= '0;
    end else begin
      if (wr_b) mem[addrb] <= dinb;
      if (wr_a) mem[addra] <= dina;
    end
  end

  // Read data is the pre-edge contents; the port decides whether to show it or din.
  assign rdata_a = mem[addra];
  assign rdata_b = mem[addrb];

  dpram_port #(
    .DATA_W    (DATA_W),
    .WRITE_MODE(WRITE_MODE_A),
    .SRVAL     (SRVAL_A),
    .OUT_REG   (OUT_REG)
  ) u_port_a (
    .clk      (clka),
    .reset    (reset),
    .access   (acc_a),
    .we       (wea),
    .din      (dina),
    .mem_rdata(rdata_a),
    .dout     (douta)
  );

  dpram_port #(
    .DATA_W    (DATA_W),
    .WRITE_MODE(WRITE_MODE_B),
    .SRVAL     (SRVAL_B),
    .OUT_REG   (OUT_REG)
  ) u_port_b (
    .clk      (clka),
    .reset    (reset),
    .access   (acc_b),
    .we       (web),
    .din      (dinb),
    .mem_rdata(rdata_b),
    .dout     (doutb)
  );

endmodule

// File: tb/tb_param_dpram.sv
// Bench for param_dpram: two builds (plain/clear-on-reset and registered/retaining)
// driven by directed and random traffic, checked against a behavioural model.
module tb_param_dpram;
  import param_dpram_pkg::*;

  localparam int DW    = 18;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  localparam logic [DW-1:0] SRVA0 = 18'h155AA;
  localparam logic [DW-1:0] SRVB0 = 18'h0AA55;
  localparam logic [DW-1:0] SRVA1 = 18'h3C3C3;
  localparam logic [DW-1:0] SRVB1 = 18'h01234;

  typedef struct packed {
    logic          rst;
    logic          en_a;
    logic          we_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] din_a;
    logic          en_b;
    logic          we_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] din_b;
  } stim_t;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  stim_t s0, s1;
  logic [DW-1:0] douta0, doutb0, douta1, doutb1;
  logic busy0, coll0, busy1, coll1;

  int total = 0;
  int bad   = 0;

  // Build 0: A write-first, B read-first, no output register, clear sweep.
  param_dpram #(
    .DATA_W(DW), .ADDR_W(AW), .WRITE_MODE_A(WM_WRITE_FIRST), .WRITE_MODE_B(WM_READ_FIRST),
    .SRVAL_A(SRVA0), .SRVAL_B(SRVB0), .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1)
  ) u_dut0 (
    .clka(clka), .reset(s0.rst),
    .ena(s0.en_a), .wea(s0.we_a), .addra(s0.addr_a), .dina(s0.din_a), .douta(douta0),
    .enb(s0.en_b), .web(s0.we_b), .addrb(s0.addr_b), .dinb(s0.din_b), .doutb(doutb0),
    .busy(busy0), .collision(coll0)
  );

  // Build 1: A no-change, B write-first, output register, memory kept across reset.
  param_dpram #(
    .DATA_W(DW), .ADDR_W(AW), .WRITE_MODE_A(WM_NO_CHANGE), .WRITE_MODE_B(WM_WRITE_FIRST),
    .SRVAL_A(SRVA1), .SRVAL_B(SRVB1), .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b0)
  ) u_dut1 (
    .clka(clka), .reset(s1.rst),
    .ena(s1.en_a), .wea(s1.we_a), .addra(s1.addr_a), .dina(s1.din_a), .douta(douta1),
    .enb(s1.en_b), .web(s1.we_b), .addrb(s1.addr_b), .dinb(s1.din_b), .doutb(doutb1),
    .busy(busy1), .collision(coll1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input bit rst, input bit ea, input bit wa, input int aa,
                               input logic [DW-1:0] da, input bit eb, input bit wb,
                               input int ab, input logic [DW-1:0] db);
    stim_t s;
    s.rst = rst;   s.en_a = ea; s.we_a = wa; s.addr_a = AW'(aa); s.din_a = da;
    s.en_b = eb;   s.we_b = wb; s.addr_b = AW'(ab); s.din_b = db;
    return s;
  endfunction

  function automatic stim_t rnd();
    int aa, ab;
    aa = int'($urandom_range(0, 15));
    ab = ($urandom_range(0, 2) == 0) ? aa : int'($urandom_range(0, 15));
    return mk(1'b0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), aa, DW'($urandom),
              $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ab, DW'($urandom));
  endfunction

  function automatic logic [DW-1:0] preload_val(input int i);
    logic [DW-1:0] v;
    v = DW'(i * 32'h01357 + 32'h00F0F);
    return (i == 5) ? 18'h2ABCD : v;
  endfunction

  // Behavioural model: per build, the memory image, what each port last latched,
  // what the output register shows, and the sweep progress.
  logic [DW-1:0] m_mem   [2][DEPTH];
  logic [DW-1:0] m_lat_a [2], m_lat_b [2], m_out_a [2], m_out_b [2];
  bit            m_busy  [2], m_coll [2], started [2];
  int            m_sweep [2];

  function automatic int mode_a(input int d); return (d == 0) ? int'(WM_WRITE_FIRST) : int'(WM_NO_CHANGE); endfunction
  function automatic int mode_b(input int d); return (d == 0) ? int'(WM_READ_FIRST) : int'(WM_WRITE_FIRST); endfunction
  function automatic logic [DW-1:0] srv_a(input int d); return (d == 0) ? SRVA0 : SRVA1; endfunction
  function automatic logic [DW-1:0] srv_b(input int d); return (d == 0) ? SRVB0 : SRVB1; endfunction

  function automatic logic [DW-1:0] port_next(input int mode, input bit acc, input bit we,
                                              input logic [DW-1:0] din, input logic [DW-1:0] old,
                                              input logic [DW-1:0] cur);
    if (!acc) return cur;
    if (!we) return old;
    if (mode == int'(WM_WRITE_FIRST)) return din;
    if (mode == int'(WM_READ_FIRST)) return old;
    return cur;
  endfunction

  task automatic model_step(input int d, input stim_t s);
    logic [DW-1:0] old_a, old_b;
    bit same;
    if (s.rst) begin
      started[d] = 1'b1;
      m_busy[d]  = (d == 0);
      m_sweep[d] = 0;
      m_coll[d]  = 1'b0;
      m_lat_a[d] = srv_a(d); m_out_a[d] = srv_a(d);
      m_lat_b[d] = srv_b(d); m_out_b[d] = srv_b(d);
      return;
    end
    m_out_a[d] = m_lat_a[d];
    m_out_b[d] = m_lat_b[d];
    m_coll[d]  = 1'b0;
    if (m_busy[d]) begin
      m_mem[d][m_sweep[d]] = '0;
      m_sweep[d]++;
      if (m_sweep[d] == DEPTH) m_busy[d] = 1'b0;
      return;
    end
    old_a = m_mem[d][s.addr_a];
    old_b = m_mem[d][s.addr_b];
    same  = (s.addr_a == s.addr_b);
    m_coll[d]  = s.en_a && s.en_b && same && (s.we_a || s.we_b);
    m_lat_a[d] = port_next(mode_a(d), s.en_a, s.we_a, s.din_a, old_a, m_lat_a[d]);
    m_lat_b[d] = port_next(mode_b(d), s.en_b, s.we_b, s.din_b, old_b, m_lat_b[d]);
    if (s.en_b && s.we_b && !(s.en_a && s.we_a && same)) m_mem[d][s.addr_b] = s.din_b;
    if (s.en_a && s.we_a) m_mem[d][s.addr_a] = s.din_a;
  endtask

  always @(posedge clka) begin
    model_step(0, s0);
    model_step(1, s1);
  end

  task automatic compare(input int d, input logic [DW-1:0] da, input logic [DW-1:0] db,
                         input logic bsy, input logic col);
    logic [DW-1:0] ea, eb;
    ea = (d == 1) ? m_out_a[d] : m_lat_a[d];
    eb = (d == 1) ? m_out_b[d] : m_lat_b[d];
    check($sformatf("d%0d.douta", d), 32'(da), 32'(ea));
    check($sformatf("d%0d.doutb", d), 32'(db), 32'(eb));
    check($sformatf("d%0d.busy", d), 32'(bsy), 32'(m_busy[d]));
    check($sformatf("d%0d.collision", d), 32'(col), 32'(m_coll[d]));
  endtask

  always @(negedge clka) begin
    if (started[0]) compare(0, douta0, doutb0, busy0, coll0);
    if (started[1]) compare(1, douta1, doutb1, busy1, coll1);
  end

  task automatic count_busy0(input string name);
    int n = 0;
    while (busy0 && n < 40) begin
      n++;
      @(negedge clka);
    end
    check(name, 32'(n), 32'd16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s0 = mk(1'b1, 0, 0, 0, '0, 0, 0, 0, '0);
    s1 = mk(1'b1, 0, 0, 0, '0, 0, 0, 0, '0);
    fork
      begin : thread0
        @(negedge clka);
        check("d0.reset_douta", 32'(douta0), 32'(SRVA0));
        check("d0.reset_doutb", 32'(doutb0), 32'(SRVB0));
        check("d0.reset_busy", 32'(busy0), 32'd1);
        check("d0.reset_coll", 32'(coll0), 32'd0);
        repeat (2) @(negedge clka);
        s0 = mk(1'b0, 0, 0, 0, '0, 0, 0, 0, '0);
        count_busy0("d0.sweep_len");
        for (int i = 0; i < DEPTH; i++) begin
          s0 = mk(1'b0, 1, 0, i, '0, 1, 0, DEPTH - 1 - i, '0);
          @(negedge clka);
          check("d0.cleared_a", 32'(douta0), 32'd0);
          check("d0.cleared_b", 32'(doutb0), 32'd0);
        end
        s0 = mk(1'b0, 1, 1, 5, 18'h2ABCD, 0, 0, 0, '0);
        @(negedge clka);
        check("d0.wf_a", 32'(douta0), 32'h2ABCD);
        s0 = mk(1'b0, 0, 0, 0, '0, 1, 1, 5, 18'h00011);
        @(negedge clka);
        check("d0.rf_b", 32'(doutb0), 32'h2ABCD);
        check("d0.hold_a", 32'(douta0), 32'h2ABCD);
        s0 = mk(1'b0, 1, 0, 5, '0, 0, 0, 0, '0);
        @(negedge clka);
        check("d0.rd5", 32'(douta0), 32'h00011);
        s0 = mk(1'b0, 1, 1, 7, 18'h11111, 1, 1, 7, 18'h22222);
        @(negedge clka);
        check("d0.ww_coll", 32'(coll0), 32'd1);
        check("d0.ww_a", 32'(douta0), 32'h11111);
        check("d0.ww_b_prior", 32'(doutb0), 32'd0);
        s0 = mk(1'b0, 0, 0, 0, '0, 1, 0, 7, '0);
        @(negedge clka);
        check("d0.ww_coll_pulse", 32'(coll0), 32'd0);
        check("d0.rd7", 32'(doutb0), 32'h11111);
        s0 = mk(1'b0, 1, 1, 2, 18'h00003, 1, 0, 2, '0);
        @(negedge clka);
        check("d0.rw_prior", 32'(doutb0), 32'd0);
        check("d0.rw_coll", 32'(coll0), 32'd1);
        s0 = mk(1'b0, 0, 0, 0, '0, 0, 0, 0, '0);
        @(negedge clka);
        check("d0.rw_coll_pulse", 32'(coll0), 32'd0);
        repeat (300) begin
          s0 = rnd();
          @(negedge clka);
        end
        s0 = mk(1'b1, 0, 0, 0, '0, 0, 0, 0, '0);
        @(negedge clka);
        s0 = mk(1'b0, 0, 0, 0, '0, 0, 0, 0, '0);
        repeat (8) @(negedge clka);
        check("d0.mid_sweep_busy", 32'(busy0), 32'd1);
        s0 = mk(1'b1, 1, 1, 3, 18'h3FFFF, 0, 0, 0, '0);
        @(negedge clka);
        check("d0.mid_reset_douta", 32'(douta0), 32'(SRVA0));
        check("d0.mid_reset_busy", 32'(busy0), 32'd1);
        @(negedge clka);
        s0 = mk(1'b0, 0, 0, 0, '0, 0, 0, 0, '0);
        count_busy0("d0.restart_len");
        repeat (100) begin
          s0 = rnd();
          @(negedge clka);
        end
        s0 = mk(1'b0, 0, 0, 0, '0, 0, 0, 0, '0);
      end
      begin : thread1
        @(negedge clka);
        check("d1.reset_douta", 32'(douta1), 32'(SRVA1));
        check("d1.reset_busy", 32'(busy1), 32'd0);
        repeat (2) @(negedge clka);
        for (int i = 0; i < DEPTH; i++) begin
          s1 = mk(1'b0, 1, 1, i, preload_val(i), 0, 0, 0, '0);
          @(negedge clka);
        end
        s1 = mk(1'b0, 0, 0, 0, '0, 0, 0, 0, '0);
        @(negedge clka);
        check("d1.nochange_hold", 32'(douta1), 32'(SRVA1));
        s1 = mk(1'b1, 0, 0, 0, '0, 0, 0, 0, '0);
        repeat (2) @(negedge clka);
        s1 = mk(1'b0, 1, 0, 5, '0, 1, 0, 3, '0);
        @(negedge clka);
        check("d1.outreg_srval_a", 32'(douta1), 32'(SRVA1));
        check("d1.outreg_srval_b", 32'(doutb1), 32'(SRVB1));
        s1 = mk(1'b0, 0, 0, 0, '0, 0, 0, 0, '0);
        @(negedge clka);
        check("d1.outreg_rd5", 32'(douta1), 32'h2ABCD);
        check("d1.kept_rd3", 32'(doutb1), 32'(preload_val(3)));
        s1 = mk(1'b0, 0, 0, 0, '0, 1, 1, 9, 18'h1F00F);
        @(negedge clka);
        check("d1.wf_b_stage", 32'(doutb1), 32'(preload_val(3)));
        s1 = mk(1'b0, 0, 0, 0, '0, 0, 0, 0, '0);
        @(negedge clka);
        check("d1.wf_b", 32'(doutb1), 32'h1F00F);
        repeat (300) begin
          s1 = rnd();
          @(negedge clka);
        end
        s1 = mk(1'b0, 0, 0, 0, '0, 0, 0, 0, '0);
      end
    join
    repeat (2) @(negedge clka);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
